alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_pkg.sv | 23 ++
 rtl/alu_driver_result_fifo.sv | 58 +++++
 rtl/alu_driver.sv | 128 ++++++++++++
 tb/tb_alu_driver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_driver_pkg.sv
// alu_driver_pkg: shared constants and the buffered result record
// for the ALU driver and its result FIFO.
package alu_driver_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;
  localparam int SH_W   = 3;
  localparam int TAG_W  = 3;
  localparam int CNT_W  = 16;
  localparam int RES_W  = DATA_W + OP_W + TAG_W;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] y;
  } res_t;

endpackage

// File: rtl/alu_driver_result_fifo.sv
// result_fifo: synchronous FIFO, DEPTH x WIDTH, head shown combinationally.
// Ports: i_clk/i_rst, i_wr_en/i_wr_data, i_rd_en, o_rd_data, o_count, o_empty.
module result_fifo
  import alu_driver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RES_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == L_FULL);
  assign w_rd      = i_rd_en & ~o_empty;
  // a full FIFO still takes a write when the head leaves the same edge
  assign w_wr      = i_wr_en & (~w_full | w_rd);
  assign o_rd_data = r_mem[r_rp];
  assign o_count   = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wr_data;
  end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: issues commands to a fixed-latency ALU and buffers tagged results.
// Ports: cmd_* in (valid/ready), alu_* drive/return, res_* out (valid/ready), err, op_count.
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_opA,
  input  logic [DATA_W-1:0] cmd_opB,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [SH_W-1:0]   cmd_shift,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [SH_W-1:0]   alu_shift_num,
  input  logic [DATA_W-1:0] alu_y,
  input  logic [OP_W-1:0]   alu_opOut,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_y,
  output logic [OP_W-1:0]   res_opcode,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_DEPTH);

  logic               w_accept;
  logic               w_cap;
  logic               w_pop;
  logic               w_empty;
  logic [CW-1:0]      w_fcount;
  logic [CW:0]        w_inflight;
  logic [CW:0]        w_used;
  res_t               w_wdata;
  res_t               w_head;

  logic               r_rdy_en;
  logic [TAG_W-1:0]   r_tag;
  logic [ALU_LAT-1:0] r_sv;
  logic [TAG_W-1:0]   r_stag [ALU_LAT];
  logic [OP_W-1:0]    r_sop  [ALU_LAT];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + (CW+1)'(r_sv[i]);
    end
  end

  // credits: every in-flight op owns a FIFO slot, so captures never drop
  assign w_used    = w_inflight + {1'b0, w_fcount};
  assign cmd_ready = r_rdy_en & (w_used < L_DEPTH);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_cap     = r_sv[ALU_LAT-1];
  assign res_valid = ~w_empty;
  assign w_pop     = res_valid & res_ready;

  always_comb begin
    w_wdata     = '0;
    w_wdata.op  = r_sop[ALU_LAT-1];
    w_wdata.tag = r_stag[ALU_LAT-1];
    w_wdata.y   = alu_y;
  end

  assign res_y      = w_head.y;
  assign res_opcode = w_head.op;
  assign res_tag    = w_head.tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdy_en      <= 1'b0;
      r_tag         <= '0;
      r_sv          <= '0;
      alu_opA       <= '0;
      alu_opB       <= '0;
      alu_opcode    <= '0;
      alu_shift_num <= '0;
      err           <= 1'b0;
      op_count      <= '0;
      for (int i = 0; i < ALU_LAT; i++) begin
        r_stag[i] <= '0;
        r_sop[i]  <= '0;
      end
    end else begin
      r_rdy_en  <= 1'b1;
      r_sv[0]   <= w_accept;
      r_stag[0] <= r_tag;
      r_sop[0]  <= cmd_opcode;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_sv[i]   <= r_sv[i-1];
        r_stag[i] <= r_stag[i-1];
        r_sop[i]  <= r_sop[i-1];
      end
      if (w_accept) begin
        alu_opA       <= cmd_opA;
        alu_opB       <= cmd_opB;
        alu_opcode    <= cmd_opcode;
        alu_shift_num <= cmd_shift;
        r_tag         <= r_tag + 1'b1;
      end
      if (w_cap && (alu_opOut != r_sop[ALU_LAT-1])) err <= 1'b1;
      if (w_pop) op_count <= op_count + 1'b1;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_wr_en   (w_cap),
    .i_wr_data (w_wdata),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_fcount),
    .o_empty   (w_empty)
  );

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed tables, corner sequences and a randomized
// scoreboard run against an ALU model with one-cycle latency.
module tb_alu_driver;
  import alu_driver_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_opA = '0;
  logic [7:0] cmd_opB = '0;
  logic [1:0] cmd_opcode = '0;
  logic [2:0] cmd_shift = '0;
  logic [7:0] alu_opA;
  logic [7:0] alu_opB;
  logic [1:0] alu_opcode;
  logic [2:0] alu_shift_num;
  logic [7:0] alu_y;
  logic [1:0] alu_opOut;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_y;
  logic [1:0] res_opcode;
  logic [2:0] res_tag;
  logic       err;
  logic [15:0] op_count;

  logic       corrupt = 1'b0;
  logic       mon_en = 1'b0;
  int         n_pass = 0;
  int         n_tot = 0;

  alu_driver #(.ALU_LAT(1), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opA(cmd_opA), .cmd_opB(cmd_opB),
    .cmd_opcode(cmd_opcode), .cmd_shift(cmd_shift),
    .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_opcode(alu_opcode), .alu_shift_num(alu_shift_num),
    .alu_y(alu_y), .alu_opOut(alu_opOut),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_opcode(res_opcode), .res_tag(res_tag),
    .err(err), .op_count(op_count)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_alu(logic [1:0] op, logic [7:0] a,
                                         logic [7:0] b, logic [2:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  // external ALU: combinational result, i.e. valid one cycle after drive
  always_comb begin
    alu_y     = ref_alu(alu_opcode, alu_opA, alu_opB, alu_shift_num);
    alu_opOut = corrupt ? 2'b11 : alu_opcode;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    corrupt = 1'b0;
    #1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sh);
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_opA = a;
    cmd_opB = b;
    cmd_shift = sh;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sh;
    logic [7:0] y;
  } vec_t;

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] op;
    logic [2:0] tag;
  } exp_t;

  vec_t       tbl [8];
  exp_t       mq [$];
  logic [2:0] m_tag;
  int         m_pops;

  // scoreboard: outstanding = accepted but not yet popped
  always @(negedge clock) begin
    if (mon_en) begin
      chk("credit", {31'd0, cmd_ready}, {31'd0, mq.size() < 4});
      if (res_valid) begin
        if (mq.size() == 0) begin
          chk("spurious_res", {31'd0, res_valid}, 32'd0);
        end else begin
          chk("rnd_y", {24'd0, res_y}, {24'd0, mq[0].y});
          chk("rnd_op", {30'd0, res_opcode}, {30'd0, mq[0].op});
          chk("rnd_tag", {29'd0, res_tag}, {29'd0, mq[0].tag});
          if (res_ready) begin
            void'(mq.pop_front());
            m_pops++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        mq.push_back({ref_alu(cmd_opcode, cmd_opA, cmd_opB, cmd_shift),
                      cmd_opcode, m_tag});
        m_tag = m_tag + 3'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int got;
    int sent;
    int stale;

    tbl[0] = '{OP_ADD, 8'h05, 8'h03, 3'd0, 8'h08};
    tbl[1] = '{OP_SUB, 8'h10, 8'h01, 3'd0, 8'h0F};
    tbl[2] = '{OP_SHL, 8'h01, 8'h00, 3'd3, 8'h08};
    tbl[3] = '{OP_SHR, 8'h80, 8'h00, 3'd2, 8'h20};
    tbl[4] = '{OP_ADD, 8'hFF, 8'h01, 3'd0, 8'h00};
    tbl[5] = '{OP_SUB, 8'h00, 8'h01, 3'd0, 8'hFF};
    tbl[6] = '{OP_SHL, 8'hA5, 8'h00, 3'd4, 8'h50};
    tbl[7] = '{OP_SHR, 8'h81, 8'h00, 3'd7, 8'h01};

    // reset state
    tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", {16'd0, op_count}, 32'd0);
    chk("rst_aluA", {24'd0, alu_opA}, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // table: single commands, latency and tag sequence
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh);
      @(negedge clock);
      chk("tbl_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("tbl_aluA", {24'd0, alu_opA}, {24'd0, tbl[i].a});
      chk("tbl_early", {31'd0, res_valid}, 32'd0);
      tick();
      chk("tbl_valid", {31'd0, res_valid}, 32'd1);
      chk("tbl_y", {24'd0, res_y}, {24'd0, tbl[i].y});
      chk("tbl_op", {30'd0, res_opcode}, {30'd0, tbl[i].op});
      chk("tbl_tag", {29'd0, res_tag}, i);
      tick();
      chk("tbl_popped", {31'd0, res_valid}, 32'd0);
    end
    chk("tbl_count", {16'd0, op_count}, 32'd8);

    // back-to-back SUB then SHL
    do_reset();
    res_ready = 1'b1;
    set_cmd(OP_SUB, 8'h10, 8'h01, 3'd0);
    tick();
    set_cmd(OP_SHL, 8'h01, 8'h00, 3'd3);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_y0", {24'd0, res_y}, 32'h0F);
    chk("b2b_tag0", {29'd0, res_tag}, 32'd0);
    tick();
    chk("b2b_y1", {24'd0, res_y}, 32'h08);
    chk("b2b_tag1", {29'd0, res_tag}, 32'd1);
    tick();
    chk("b2b_empty", {31'd0, res_valid}, 32'd0);

    // backpressure: only FIFO_DEPTH credits
    do_reset();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      set_cmd(OP_ADD, 8'(acc), 8'h01, 3'd0);
      @(negedge clock);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 32'd4);
    chk("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
    res_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (res_valid) begin
        chk("bp_y", {24'd0, res_y}, got + 1);
        chk("bp_tag", {29'd0, res_tag}, got);
        got++;
      end
      tick();
    end
    chk("bp_drained", got, 32'd4);

    // opcode echo mismatch is sticky
    do_reset();
    res_ready = 1'b1;
    corrupt = 1'b1;
    set_cmd(OP_ADD, 8'h01, 8'h02, 3'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_y", {24'd0, res_y}, 32'h03);
    chk("err_op", {30'd0, res_opcode}, 32'd0);
    corrupt = 1'b0;
    tick();
    set_cmd(OP_SUB, 8'h09, 8'h04, 3'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // reset mid-operation
    do_reset();
    res_ready = 1'b1;
    corrupt = 1'b1;
    set_cmd(OP_ADD, 8'h01, 8'h01, 3'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    corrupt = 1'b0;
    chk("mid_cnt_pre", {16'd0, op_count}, 32'd1);
    chk("mid_err_pre", {31'd0, err}, 32'd1);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_cmd(OP_ADD, 8'(k), 8'h10, 3'd0);
      tick();
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_cnt", {16'd0, op_count}, 32'd0);
    chk("mid_err", {31'd0, err}, 32'd0);
    chk("mid_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_aluA", {24'd0, alu_opA}, 32'd0);
    tick();
    reset = 1'b0;
    res_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (res_valid) stale++;
      tick();
    end
    chk("mid_no_stale", stale, 32'd0);

    // nine back-to-back commands, tag wrap and op_count
    do_reset();
    res_ready = 1'b1;
    sent = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent < 9) set_cmd(OP_ADD, 8'(sent), 8'h00, 3'd0);
      else cmd_valid = 1'b0;
      @(negedge clock);
      if (cmd_valid) begin
        chk("wrap_ready", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready) sent++;
      end
      if (res_valid) begin
        chk("wrap_tag", {29'd0, res_tag}, got % 8);
        got++;
      end
      tick();
    end
    chk("wrap_got", got, 32'd9);
    chk("wrap_count", {16'd0, op_count}, 32'd9);

    // randomized traffic against the scoreboard
    do_reset();
    mq.delete();
    m_tag = '0;
    m_pops = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(3) != 0);
      cmd_opcode = 2'($urandom_range(3));
      cmd_opA = 8'($urandom);
      cmd_opB = 8'($urandom);
      cmd_shift = 3'($urandom_range(7));
      res_ready = ($urandom_range(2) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (10) tick();
    mon_en = 1'b0;
    chk("rnd_drained", mq.size(), 32'd0);
    chk("rnd_count", {16'd0, op_count}, m_pops);
    chk("rnd_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
